// File: rtl/hazard_unit.sv
// Purpose: hazard, forwarding and redirect control for the 5-stage RISC-V pipeline, plus debug FSM/counters.
// Latency: stall/flush/forward/PCSrcE are combinational (0 cycles); hz_state, counters and stall_err update 1 edge later.
// Backpressure: none accepted; the unit asserts StallF/StallD to hold the front end on a load-use dependency.
//
// Ports:
//   clk, rst_n                  pipeline clock, asynchronous active-low reset
//   Rs1D, Rs2D                  Decode source registers
//   Rs1E, Rs2E, RdE             Execute source/destination registers
//   RdM, RdW                    Memory / Writeback destination registers
//   RegWriteM, RegWriteW        Memory / Writeback write enables
//   ResultSrcE                  Execute result-source select (LOAD_SRC marks a load)
//   JumpE, BranchE, ZeroE       Execute control-flow flags
//   clr_cnt                     synchronous clear of counters and stall_err
//   ForwardAE, ForwardBE        operand forward select (00 RF, 01 WB, 10 MEM)
//   StallF, StallD              hold PC and F->D register
//   FlushD, FlushE              bubble F->D and D->E registers
//   PCSrcE                      take branch/jump target
//   hz_state                    event FSM state (00 RUN, 01 STALLED, 10 REDIRECT)
//   stall_cnt, flush_cnt, taken_cnt  saturating event counters
//   stall_err                   sticky: load-use stall on two consecutive cycles

module hazard_unit #(
  parameter int         CNT_WIDTH = 32,
  parameter logic [1:0] LOAD_SRC  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic [1:0]           ResultSrcE,
  input  logic                 JumpE,
  input  logic                 BranchE,
  input  logic                 ZeroE,
  input  logic                 clr_cnt,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 PCSrcE,
  output logic [1:0]           hz_state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt,
  output logic                 stall_err
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALLED  = 2'b01,
    REDIRECT = 2'b10
  } hzState_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  hzState_t state;
  hzState_t stateNext;

  logic redirect;
  logic loadUse;
  logic lwStall;
  logic flushAny;

  // Forward select for one Execute source operand. Memory holds the younger
  // result so it wins over Writeback; x0 is hardwired zero and never forwards.
  function automatic logic [1:0] fwdSel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) begin
      sel = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Saturating increment: stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] incSat(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational hazard detection. Purely input-driven; the registered state
  // never feeds these. Everything is gated by rst_n so the pipeline sees a
  // quiet control word while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    redirect = 1'b0;
    loadUse  = 1'b0;
    lwStall  = 1'b0;
    flushAny = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      redirect = JumpE | (BranchE & ZeroE);
      loadUse  = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
      // A redirect squashes the dependent Decode instruction anyway, so
      // stalling for it would only waste a cycle.
      lwStall  = loadUse & ~redirect;
      flushAny = lwStall | redirect;
      ForwardAE = fwdSel(Rs1E);
      ForwardBE = fwdSel(Rs2E);
    end
  end

  assign PCSrcE = redirect;
  assign StallF = lwStall;
  assign StallD = lwStall;
  assign FlushD = redirect;
  assign FlushE = flushAny;

  // ---------------------------------------------------------------------------
  // Event-history FSM: reflects what happened in the previous cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = RUN;
    if (redirect) begin
      stateNext = REDIRECT;
    end else if (lwStall) begin
      stateNext = STALLED;
    end
  end

  assign hz_state = state;

  // ---------------------------------------------------------------------------
  // Performance counters and sticky error. A load-use stall resolves in one
  // cycle, so a second consecutive stall points at a broken pipeline.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      taken_cnt <= '0;
      stall_err <= 1'b0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      taken_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      if (lwStall) begin
        stall_cnt <= incSat(stall_cnt);
      end
      if (flushAny) begin
        flush_cnt <= incSat(flush_cnt);
      end
      if (redirect) begin
        taken_cnt <= incSat(taken_cnt);
      end
      if (lwStall && (state == STALLED)) begin
        stall_err <= 1'b1;
      end
    end
  end

endmodule
